// File: rtl/decode_stage_pkg.sv
// Shared Y86-64 encodings and the E-stage bundle type for the decode stage.
package decode_stage_pkg;

  localparam int NREG = 15;
  localparam int W    = 64;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [W-1:0] valC;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [3:0]   srcA;
    logic [3:0]   srcB;
  } e_bundle_t;

  localparam e_bundle_t E_BUBBLE = '{
    icode: INOP,
    ifun:  4'h0,
    valA:  '0,
    valB:  '0,
    valC:  '0,
    dstE:  RNONE,
    dstM:  RNONE,
    srcA:  RNONE,
    srcB:  RNONE
  };

endpackage

// File: rtl/decode_stage_regfile.sv
// 15x64 register file: two asynchronous read ports, two write ports where the
// M port overrides the E port on a shared target (popq %rsp).
module decode_stage_regfile
  import decode_stage_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [3:0]   rd_a_addr_i,
  input  logic [3:0]   rd_b_addr_i,
  output logic [W-1:0] rd_a_data_o,
  output logic [W-1:0] rd_b_data_o,
  input  logic [3:0]   wr_e_addr_i,
  input  logic [W-1:0] wr_e_data_i,
  input  logic [3:0]   wr_m_addr_i,
  input  logic [W-1:0] wr_m_data_i
);

  logic [W-1:0] r_regs [NREG];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        // M assignment comes last so it wins when both ports hit one register
        if (wr_e_addr_i == 4'(i)) r_regs[i] <= wr_e_data_i;
        if (wr_m_addr_i == 4'(i)) r_regs[i] <= wr_m_data_i;
      end
    end
  end

  assign rd_a_data_o = (rd_a_addr_i == RNONE) ? '0 : r_regs[rd_a_addr_i];
  assign rd_b_data_o = (rd_b_addr_i == RNONE) ? '0 : r_regs[rd_b_addr_i];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 pipelined decode/write-back: source/destination select, operand
// forwarding from e/M/W, and the registered E-stage bundle.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [3:0]   D_icode_i,
  input  logic [3:0]   D_ifun_i,
  input  logic [3:0]   D_rA_i,
  input  logic [3:0]   D_rB_i,
  input  logic [W-1:0] D_valC_i,
  input  logic [W-1:0] D_valP_i,
  input  logic         E_stall_i,
  input  logic         E_bubble_i,
  input  logic [3:0]   e_dstE_i,
  input  logic [W-1:0] e_valE_i,
  input  logic [3:0]   M_dstE_i,
  input  logic [W-1:0] M_valE_i,
  input  logic [3:0]   M_dstM_i,
  input  logic [W-1:0] m_valM_i,
  input  logic [3:0]   W_dstE_i,
  input  logic [W-1:0] W_valE_i,
  input  logic [3:0]   W_dstM_i,
  input  logic [W-1:0] W_valM_i,
  output logic [3:0]   d_srcA_o,
  output logic [3:0]   d_srcB_o,
  output logic [3:0]   E_icode_o,
  output logic [3:0]   E_ifun_o,
  output logic [W-1:0] E_valA_o,
  output logic [W-1:0] E_valB_o,
  output logic [W-1:0] E_valC_o,
  output logic [3:0]   E_dstE_o,
  output logic [3:0]   E_dstM_o,
  output logic [3:0]   E_srcA_o,
  output logic [3:0]   E_srcB_o
);

  logic [3:0]   w_srcA;
  logic [3:0]   w_srcB;
  logic [3:0]   w_dstE;
  logic [3:0]   w_dstM;
  logic [W-1:0] w_rvalA;
  logic [W-1:0] w_rvalB;
  logic [W-1:0] w_valA;
  logic [W-1:0] w_valB;
  e_bundle_t    w_d_bundle;
  e_bundle_t    r_e;

  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (D_icode_i)
      IRRMOVQ: begin w_srcA = D_rA_i; w_dstE = D_rB_i; end
      IIRMOVQ: begin w_dstE = D_rB_i; end
      IRMMOVQ: begin w_srcA = D_rA_i; w_srcB = D_rB_i; end
      IMRMOVQ: begin w_srcB = D_rB_i; w_dstM = D_rA_i; end
      IOPQ:    begin w_srcA = D_rA_i; w_srcB = D_rB_i; w_dstE = D_rB_i; end
      ICALL:   begin w_srcB = RSP; w_dstE = RSP; end
      IRET:    begin w_srcA = RSP; w_srcB = RSP; w_dstE = RSP; end
      IPUSHQ:  begin w_srcA = D_rA_i; w_srcB = RSP; w_dstE = RSP; end
      IPOPQ:   begin w_srcA = RSP; w_srcB = RSP; w_dstE = RSP; w_dstM = D_rA_i; end
      default: ;
    endcase
  end

  assign d_srcA_o = w_srcA;
  assign d_srcB_o = w_srcB;

  decode_stage_regfile u_regfile (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .rd_a_addr_i (w_srcA),
    .rd_b_addr_i (w_srcB),
    .rd_a_data_o (w_rvalA),
    .rd_b_data_o (w_rvalB),
    .wr_e_addr_i (W_dstE_i),
    .wr_e_data_i (W_valE_i),
    .wr_m_addr_i (W_dstM_i),
    .wr_m_data_i (W_valM_i)
  );

  // Youngest producer first; RNONE never forwards
  function automatic logic [W-1:0] fwd(input logic [3:0] src, input logic [W-1:0] rf_val);
    if (src == RNONE)         return rf_val;
    else if (src == e_dstE_i) return e_valE_i;
    else if (src == M_dstM_i) return m_valM_i;
    else if (src == M_dstE_i) return M_valE_i;
    else if (src == W_dstM_i) return W_valM_i;
    else if (src == W_dstE_i) return W_valE_i;
    else                      return rf_val;
  endfunction

  assign w_valA = (D_icode_i == ICALL || D_icode_i == IJXX) ? D_valP_i : fwd(w_srcA, w_rvalA);
  assign w_valB = fwd(w_srcB, w_rvalB);

  always_comb begin
    w_d_bundle       = E_BUBBLE;
    w_d_bundle.icode = D_icode_i;
    w_d_bundle.ifun  = D_ifun_i;
    w_d_bundle.valA  = w_valA;
    w_d_bundle.valB  = w_valB;
    w_d_bundle.valC  = D_valC_i;
    w_d_bundle.dstE  = w_dstE;
    w_d_bundle.dstM  = w_dstM;
    w_d_bundle.srcA  = w_srcA;
    w_d_bundle.srcB  = w_srcB;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)        r_e <= E_BUBBLE;
    else if (E_bubble_i) r_e <= E_BUBBLE;
    else if (!E_stall_i) r_e <= w_d_bundle;
  end

  assign E_icode_o = r_e.icode;
  assign E_ifun_o  = r_e.ifun;
  assign E_valA_o  = r_e.valA;
  assign E_valB_o  = r_e.valB;
  assign E_valC_o  = r_e.valC;
  assign E_dstE_o  = r_e.dstE;
  assign E_dstM_o  = r_e.dstM;
  assign E_srcA_o  = r_e.srcA;
  assign E_srcB_o  = r_e.srcB;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  D_icode_i, D_ifun_i, D_rA_i, D_rB_i;
  logic [63:0] D_valC_i, D_valP_i;
  logic        E_stall_i, E_bubble_i;
  logic [3:0]  e_dstE_i, M_dstE_i, M_dstM_i, W_dstE_i, W_dstM_i;
  logic [63:0] e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i;
  logic [3:0]  d_srcA_o, d_srcB_o, E_icode_o, E_ifun_o;
  logic [63:0] E_valA_o, E_valB_o, E_valC_o;
  logic [3:0]  E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  decode_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .D_icode_i(D_icode_i), .D_ifun_i(D_ifun_i), .D_rA_i(D_rA_i), .D_rB_i(D_rB_i),
    .D_valC_i(D_valC_i), .D_valP_i(D_valP_i),
    .E_stall_i(E_stall_i), .E_bubble_i(E_bubble_i),
    .e_dstE_i(e_dstE_i), .e_valE_i(e_valE_i),
    .M_dstE_i(M_dstE_i), .M_valE_i(M_valE_i), .M_dstM_i(M_dstM_i), .m_valM_i(m_valM_i),
    .W_dstE_i(W_dstE_i), .W_valE_i(W_valE_i), .W_dstM_i(W_dstM_i), .W_valM_i(W_valM_i),
    .d_srcA_o(d_srcA_o), .d_srcB_o(d_srcB_o),
    .E_icode_o(E_icode_o), .E_ifun_o(E_ifun_o),
    .E_valA_o(E_valA_o), .E_valB_o(E_valB_o), .E_valC_o(E_valC_o),
    .E_dstE_o(E_dstE_o), .E_dstM_o(E_dstM_o), .E_srcA_o(E_srcA_o), .E_srcB_o(E_srcB_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic decode(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [3:0] ra, input logic [3:0] rb);
    D_icode_i = icode; D_ifun_i = ifun; D_rA_i = ra; D_rB_i = rb;
  endtask

  task automatic clear_fwd();
    e_dstE_i = 4'hF; M_dstE_i = 4'hF; M_dstM_i = 4'hF; W_dstE_i = 4'hF; W_dstM_i = 4'hF;
    e_valE_i = '0; M_valE_i = '0; m_valM_i = '0; W_valE_i = '0; W_valM_i = '0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    decode(4'h1, 4'h0, 4'hF, 4'hF);
    D_valC_i = '0; D_valP_i = '0;
    E_stall_i = 1'b0; E_bubble_i = 1'b0;
    clear_fwd();

    // reset state
    #12;
    chk("rst_icode", 64'(E_icode_o), 64'h1);
    chk("rst_dstE",  64'(E_dstE_o),  64'hF);
    chk("rst_srcA",  64'(E_srcA_o),  64'hF);
    chk("rst_valA",  E_valA_o,       64'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();

    // regfile reads zero after reset; combinational src select
    decode(4'h6, 4'h0, 4'h1, 4'h2);
    D_valC_i = 64'hABCD;
    #1;
    chk("d_srcA_opq", 64'(d_srcA_o), 64'h1);
    chk("d_srcB_opq", 64'(d_srcB_o), 64'h2);
    step();
    chk("rf0_valA", E_valA_o, 64'h0);
    chk("rf0_valB", E_valB_o, 64'h0);
    chk("opq_dstE", 64'(E_dstE_o), 64'h2);
    chk("opq_valC", E_valC_o, 64'hABCD);

    // write-back then read
    decode(4'h1, 4'h0, 4'hF, 4'hF);
    W_dstE_i = 4'h3; W_valE_i = 64'h55;
    step();
    clear_fwd();
    decode(4'h6, 4'h0, 4'h3, 4'h3);
    step();
    chk("wb_valA", E_valA_o, 64'h55);
    chk("wb_valB", E_valB_o, 64'h55);
    chk("wb_dstE", 64'(E_dstE_o), 64'h3);

    // same-cycle write-back reaches E via W forwarding
    decode(4'h2, 4'h0, 4'h5, 4'h6);
    W_dstE_i = 4'h5; W_valE_i = 64'h77;
    step();
    chk("wfwd_valA", E_valA_o, 64'h77);
    chk("rrmov_valB", E_valB_o, 64'h0);
    chk("rrmov_dstE", 64'(E_dstE_o), 64'h6);
    clear_fwd();

    // forwarding priority
    decode(4'h6, 4'h0, 4'h2, 4'h7);
    e_dstE_i = 4'h2; e_valE_i = 64'h11;
    M_dstE_i = 4'h2; M_valE_i = 64'h22;
    W_dstE_i = 4'h2; W_valE_i = 64'h33;
    step();
    chk("fwd_e", E_valA_o, 64'h11);
    e_dstE_i = 4'hF;
    M_dstM_i = 4'h2; m_valM_i = 64'h44;
    step();
    chk("fwd_mM", E_valA_o, 64'h44);
    M_dstM_i = 4'hF;
    step();
    chk("fwd_mE", E_valA_o, 64'h22);
    M_dstE_i = 4'hF;
    W_dstM_i = 4'h2; W_valM_i = 64'h66;
    step();
    chk("fwd_wM", E_valA_o, 64'h66);
    clear_fwd();
    step();
    chk("rf_mport_wins", E_valA_o, 64'h66);
    M_dstE_i = 4'h7; M_valE_i = 64'h99;
    step();
    chk("fwd_valB", E_valB_o, 64'h99);
    clear_fwd();

    // both write ports hit RSP: M wins
    decode(4'h1, 4'h0, 4'hF, 4'hF);
    W_dstE_i = 4'h4; W_valE_i = 64'h1;
    W_dstM_i = 4'h4; W_valM_i = 64'h2;
    step();
    clear_fwd();
    decode(4'h9, 4'h0, 4'hF, 4'hF);
    step();
    chk("rsp_both_A", E_valA_o, 64'h2);
    chk("rsp_both_B", E_valB_o, 64'h2);

    // CALL
    decode(4'h1, 4'h0, 4'hF, 4'hF);
    W_dstE_i = 4'h4; W_valE_i = 64'h200;
    step();
    clear_fwd();
    decode(4'h8, 4'h0, 4'hF, 4'hF);
    D_valP_i = 64'h100;
    step();
    chk("call_valA", E_valA_o, 64'h100);
    chk("call_valB", E_valB_o, 64'h200);
    chk("call_dstE", 64'(E_dstE_o), 64'h4);
    chk("call_dstM", 64'(E_dstM_o), 64'hF);
    chk("call_srcA", 64'(E_srcA_o), 64'hF);

    // POPQ and invalid icode
    decode(4'hB, 4'h0, 4'h3, 4'hF);
    step();
    chk("pop_dstM", 64'(E_dstM_o), 64'h3);
    chk("pop_valA", E_valA_o, 64'h200);
    decode(4'hC, 4'h0, 4'h3, 4'h3);
    step();
    chk("inv_icode", 64'(E_icode_o), 64'hC);
    chk("inv_srcA",  64'(E_srcA_o),  64'hF);
    chk("inv_dstE",  64'(E_dstE_o),  64'hF);

    // JXX passes valP and ifun
    decode(4'h7, 4'h3, 4'hF, 4'hF);
    D_valP_i = 64'h345;
    step();
    chk("jxx_valA", E_valA_o, 64'h345);
    chk("jxx_ifun", 64'(E_ifun_o), 64'h3);

    // stall holds, bubble beats stall
    E_stall_i = 1'b1;
    decode(4'h6, 4'h0, 4'h3, 4'h3);
    step();
    chk("stall_icode", 64'(E_icode_o), 64'h7);
    chk("stall_valA",  E_valA_o, 64'h345);
    E_bubble_i = 1'b1;
    step();
    chk("bub_icode", 64'(E_icode_o), 64'h1);
    chk("bub_dstE",  64'(E_dstE_o), 64'hF);
    chk("bub_valA",  E_valA_o, 64'h0);
    E_stall_i = 1'b0; E_bubble_i = 1'b0;

    // mid-stream asynchronous reset
    step();
    chk("pre_rst_valA", E_valA_o, 64'h55);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_icode", 64'(E_icode_o), 64'h1);
    chk("arst_valA",  E_valA_o, 64'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();
    chk("arst_rf_cleared", E_valA_o, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined Y86-64 decode/write-back stage, sitting directly upstream of the execute block.
- Holds the 15x64 register file and selects srcA/srcB/dstE/dstM from icode.
- Resolves data hazards by forwarding from the execute, memory and write-back stages.
- Drives the registered E-stage bundle (icode, ifun, valA, valB, valC, dstE, dstM) consumed by execute.

Parameters:
- NREG, 15, architectural registers (IDs 0..14; ID 15 = RNONE).
- W, 64, data width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- D_icode_i  in  4  fetched icode.
- D_ifun_i  in  4  fetched ifun.
- D_rA_i  in  4  rA field.
- D_rB_i  in  4  rB field.
- D_valC_i  in  64  constant.
- D_valP_i  in  64  next PC.
- E_stall_i  in  1  hold E register.
- E_bubble_i  in  1  load NOP bubble into E register.
- e_dstE_i  in  4  execute-stage dstE (after cmov condition).
- e_valE_i  in  64  execute result.
- M_dstE_i  in  4  memory-stage dstE.
- M_valE_i  in  64  memory-stage valE.
- M_dstM_i  in  4  memory-stage dstM.
- m_valM_i  in  64  memory read data.
- W_dstE_i  in  4  write-back dstE.
- W_valE_i  in  64  write-back valE.
- W_dstM_i  in  4  write-back dstM.
- W_valM_i  in  64  write-back valM.
- d_srcA_o  out  4  combinational srcA, for hazard control.
- d_srcB_o  out  4  combinational srcB, for hazard control.
- E_icode_o  out  4  registered to execute.
- E_ifun_o  out  4  registered to execute.
- E_valA_o  out  64  registered to execute.
- E_valB_o  out  64  registered to execute.
- E_valC_o  out  64  registered to execute.
- E_dstE_o  out  4  registered to execute.
- E_dstM_o  out  4  registered to execute.
- E_srcA_o  out  4  registered to execute.
- E_srcB_o  out  4  registered to execute.

Behaviour:
- Clock/reset: one clock, clk_i. rst_n_i is asynchronous and active-low.
- Reset state:
  - All 15 registers = 0.
  - E bundle = bubble: icode INOP, ifun 0, valA/valB/valC 0, dst*/src* RNONE.
- Source select (combinational):
  - srcA = rA for RRMOVQ/RMMOVQ/OPQ/PUSHQ; RSP for POPQ/RET; else RNONE.
  - srcB = rB for OPQ/RMMOVQ/MRMOVQ; RSP for PUSHQ/POPQ/CALL/RET; else RNONE.
- Destination select (combinational):
  - dstE = rB for RRMOVQ/IRMOVQ/OPQ; RSP for PUSHQ/POPQ/CALL/RET; else RNONE.
  - dstM = rA for MRMOVQ/POPQ; else RNONE.
- Register file reads:
  - Asynchronous read; RNONE reads 0.
- Register file writes:
  - Two write ports on the rising edge: W_dstE_i/W_valE_i and W_dstM_i/W_valM_i.
  - RNONE = no write.
  - Both ports targeting the same register: the M port wins (popq %rsp semantics).
- valA selection, in priority order:
  1. D_valP_i for CALL/JXX.
  2. srcA==e_dstE -> e_valE.
  3. srcA==M_dstM -> m_valM.
  4. srcA==M_dstE -> M_valE.
  5. srcA==W_dstM -> W_valM.
  6. srcA==W_dstE -> W_valE.
  7. Register file.
  - srcA==RNONE never matches any forwarding source.
- valB selection:
  - Same forwarding chain as valA, keyed on srcB.
  - No valP case.
- E register update:
  - E_bubble_i=1 -> load the bubble (bubble wins over stall).
  - Else E_stall_i=1 -> hold.
  - Else load the decoded values.
  - Latency: decode-to-E is 1 cycle.
- Write-back vs. read in the same cycle: the new value reaches E via W forwarding, with no extra cycle.
- Invalid icode (>IPOPQ): src/dst = RNONE; icode passes through unchanged so execute/status logic flags it.
- Reset asserted mid-operation: register file and E register clear immediately (asynchronous); no partial writes persist.

Decomposition:
- define.v carries:
  - icode constants IHALT..IPOPQ.
  - RSP=4'h4 and RNONE=4'hF.
  - The bubble constant set.
- Sub-module regfile: 15x64, 2 asynchronous read ports, 2 synchronous write ports with M-port priority, asynchronous clear.
- decode_stage contains the select/forward logic and the E register.

Test Plan:
- Reset:
  - Stimulus: hold rst_n_i=0, then release.
  - Required: E_icode_o=INOP, E_dstE_o=F, E_valA_o=0; regfile reads 0.
- Write-back then read:
  - Stimulus: W_dstE=3, W_valE=0x55, then decode OPQ rA=3 rB=3.
  - Required: next cycle E_valA_o=E_valB_o=0x55, E_dstE_o=3.
- Forwarding priority:
  - Stimulus: srcA=2 with e_dstE=2 (0x11), M_dstE=2 (0x22), W_dstE=2 (0x33).
  - Required: E_valA_o=0x11.
  - Stimulus: remove e, keep M_dstM=2 (m_valM 0x44) and M_dstE=2.
  - Required: 0x44.
- CALL:
  - Stimulus: D_valP=0x100, RSP=0x200.
  - Required: E_valA_o=0x100, E_valB_o=0x200, E_dstE_o=4, E_dstM_o=F.
- Both write ports hit RSP:
  - Stimulus: W_dstE=W_dstM=4, valE=1, valM=2.
  - Required: RSP reads 2.
- Stall/bubble:
  - Stimulus: stall -> E unchanged across edge; bubble+stall together.
  - Required: bubble loaded (INOP, RNONE).
  - Stimulus: reset pulse mid-stream.
  - Required: all cleared asynchronously.
